// File: rtl/nlms_sample_loader.sv
// -----------------------------------------------------------------------------
// nlms_sample_loader
//
// Purpose:
//   Upstream stage of the NLMS engine. Accepts paired raw reference (x) and
//   desired (d) samples on a valid/ready stream. It converts each sample to
//   signed Q-format with SAMPLE_Q_FORMAT fraction bits, then writes the pair
//   into one of two ping/pong buffers owned by the NLMS datapath. When a block
//   of cfg_count samples is complete, it reports this and moves on to the other
//   buffer. While the datapath still owns the next target buffer, the loader
//   stalls the input stream.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start, abort    1-cycle control pulses (start latches cfg_*)
//   cfg_count       samples per block, 0 (or anything above depth) = depth
//   cfg_u2          1: raw is two's complement, 0: offset binary
//   cfg_fract       1: raw is a fraction in [-1,1), 0: raw is an integer
//   cfg_input_bits  valid raw bits N (LSB-aligned), 1..SAMPLE_WIDTH
//   s_valid/s_ready input stream handshake; s_x/s_d raw samples
//   wr_en/wr_sel/wr_addr/wr_x/wr_d  registered buffer write port
//   blk_done/blk_sel                1-cycle block-complete pulse and its buffer
//   rel/rel_sel                     datapath releases buffer rel_sel
//   busy                            loader is not idle
//   sat_flag                        sticky conversion-saturation flag
// -----------------------------------------------------------------------------
module nlms_sample_loader #(
    parameter int LOG2_X_D_BUFF_HEIGHT = 7,
    parameter int SAMPLE_WIDTH         = 16,
    parameter int SAMPLE_Q_FORMAT      = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [LOG2_X_D_BUFF_HEIGHT:0]     cfg_count,
    input  logic                              cfg_u2,
    input  logic                              cfg_fract,
    input  logic [$clog2(SAMPLE_WIDTH):0]     cfg_input_bits,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [SAMPLE_WIDTH-1:0]           s_x,
    input  logic [SAMPLE_WIDTH-1:0]           s_d,
    output logic                              wr_en,
    output logic                              wr_sel,
    output logic [LOG2_X_D_BUFF_HEIGHT-1:0]   wr_addr,
    output logic [SAMPLE_WIDTH-1:0]           wr_x,
    output logic [SAMPLE_WIDTH-1:0]           wr_d,
    output logic                              blk_done,
    output logic                              blk_sel,
    input  logic                              rel,
    input  logic                              rel_sel,
    output logic                              busy,
    output logic                              sat_flag
);

    localparam int AW    = LOG2_X_D_BUFF_HEIGHT;
    localparam int CW    = LOG2_X_D_BUFF_HEIGHT + 1;
    localparam int SW    = SAMPLE_WIDTH;
    localparam int Q     = SAMPLE_Q_FORMAT;
    localparam int NBW   = $clog2(SAMPLE_WIDTH) + 1;
    localparam int DEPTH = 1 << LOG2_X_D_BUFF_HEIGHT;
    localparam int W2    = 2 * SAMPLE_WIDTH;

    // Saturation limits of the SW-bit signed result, held at the 2*SW working width.
    localparam logic signed [W2-1:0] MAX_V = (W2'(1) <<< (SW - 1)) - W2'(1);
    localparam logic signed [W2-1:0] MIN_V = ~MAX_V;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic          sat;
        logic [SW-1:0] val;
    } conv_t;

    // Raw-to-Q conversion. The sample is reduced to its low n bits, made two's
    // complement and sign-extended. It is then scaled at 2*SW bits, so no
    // intermediate value can overflow before the final saturation.
    function automatic conv_t convert(input logic [SW-1:0]  raw,
                                      input logic [NBW-1:0] n,
                                      input logic           u2,
                                      input logic           fract);
        conv_t                 res;
        int                    n_i;
        int                    lsh;
        int                    fsh;
        logic [W2-1:0]         mask;
        logic [W2-1:0]         r;
        logic signed [W2-1:0]  e;
        logic signed [W2-1:0]  v;
        n_i  = int'(n);
        mask = (W2'(1) << n_i) - W2'(1);
        r    = {{(W2 - SW){1'b0}}, raw} & mask;
        // Offset binary becomes two's complement when its top valid bit is flipped.
        if (!u2)
            r = r ^ (W2'(1) << (n_i - 1));
        // Move bit n-1 to the MSB, then shift it back arithmetically to sign-extend.
        lsh = W2 - n_i;
        e   = $signed(r << lsh) >>> lsh;
        if (fract) begin
            // A fraction in [-1,1) with n bits has n-1 fraction bits; realign to Q.
            fsh = Q + 1 - n_i;
            if (fsh >= 0)
                v = e <<< fsh;
            else
                v = e >>> (-fsh);   // arithmetic shift: truncates toward -inf
        end else begin
            v = e <<< Q;
        end
        res.sat = 1'b0;
        if (v > MAX_V) begin
            res.val = MAX_V[SW-1:0];
            res.sat = 1'b1;
        end else if (v < MIN_V) begin
            res.val = MIN_V[SW-1:0];
            res.sat = 1'b1;
        end else begin
            res.val = v[SW-1:0];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t          state_q, state_d;
    logic            fill_sel_q, fill_sel_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [1:0]      buf_full_q, buf_full_d;
    logic [AW-1:0]   cfg_last_q, cfg_last_d;     // address of the last sample in a block
    logic            cfg_u2_q, cfg_u2_d;
    logic            cfg_fract_q, cfg_fract_d;
    logic [NBW-1:0]  cfg_bits_q, cfg_bits_d;

    logic            wr_en_d, wr_sel_d, blk_done_d, blk_sel_d, sat_flag_d;
    logic [AW-1:0]   wr_addr_d;
    logic [SW-1:0]   wr_x_d, wr_d_d;

    conv_t           conv_x, conv_d;
    logic            accept;
    logic            last;
    logic [1:0]      rel_mask;

    assign s_ready = (state_q == FILL);
    assign busy    = (state_q != IDLE);
    assign accept  = s_valid && s_ready;
    assign last    = accept && (addr_q == cfg_last_q);

    // Clearing a bit that is already 0 has no effect. A release of a buffer
    // that is not full is therefore ignored without any extra logic.
    assign rel_mask = rel ? (rel_sel ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        conv_x = convert(s_x, cfg_bits_q, cfg_u2_q, cfg_fract_q);
        conv_d = convert(s_d, cfg_bits_q, cfg_u2_q, cfg_fract_q);
    end

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default value first. That way no path
        // through the case statement leaves a value unassigned and infers a latch.
        state_d     = state_q;
        fill_sel_d  = fill_sel_q;
        addr_d      = addr_q;
        buf_full_d  = buf_full_q;
        cfg_last_d  = cfg_last_q;
        cfg_u2_d    = cfg_u2_q;
        cfg_fract_d = cfg_fract_q;
        cfg_bits_d  = cfg_bits_q;
        wr_en_d     = 1'b0;
        wr_sel_d    = fill_sel_q;
        wr_addr_d   = addr_q;
        wr_x_d      = '0;
        wr_d_d      = '0;
        blk_done_d  = 1'b0;
        blk_sel_d   = fill_sel_q;
        sat_flag_d  = sat_flag;

        if (abort) begin
            // Abort wins over everything, including a pair presented this cycle.
            state_d    = IDLE;
            fill_sel_d = 1'b0;
            addr_d     = '0;
            buf_full_d = 2'b00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d     = FILL;
                        sat_flag_d  = 1'b0;
                        cfg_u2_d    = cfg_u2;
                        cfg_fract_d = cfg_fract;
                        cfg_bits_d  = (cfg_input_bits == '0 || cfg_input_bits > NBW'(SW))
                                      ? NBW'(SW) : cfg_input_bits;
                        cfg_last_d  = (cfg_count == '0 || cfg_count > CW'(DEPTH))
                                      ? AW'(DEPTH - 1) : AW'(cfg_count - CW'(1));
                    end
                end

                FILL: begin
                    buf_full_d = buf_full_q & ~rel_mask;
                    if (accept) begin
                        wr_en_d = 1'b1;
                        wr_x_d  = conv_x.val;
                        wr_d_d  = conv_d.val;
                        if (conv_x.sat || conv_d.sat)
                            sat_flag_d = 1'b1;
                        if (last) begin
                            addr_d                 = '0;
                            buf_full_d[fill_sel_q] = 1'b1;
                            fill_sel_d             = ~fill_sel_q;
                            blk_done_d             = 1'b1;
                            // The decision uses the post-release value, so a
                            // release on this same edge avoids the stall.
                            if (buf_full_d[~fill_sel_q])
                                state_d = WAIT;
                        end else begin
                            addr_d = addr_q + AW'(1);
                        end
                    end
                end

                WAIT: begin
                    buf_full_d = buf_full_q & ~rel_mask;
                    if (!buf_full_d[fill_sel_q])
                        state_d = FILL;
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    // All registers read their old values on the same edge, whatever order
    // the blocks are evaluated in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fill_sel_q  <= 1'b0;
            addr_q      <= '0;
            buf_full_q  <= 2'b00;
            cfg_last_q  <= '0;
            cfg_u2_q    <= 1'b0;
            cfg_fract_q <= 1'b0;
            cfg_bits_q  <= '0;
        end else begin
            state_q     <= state_d;
            fill_sel_q  <= fill_sel_d;
            addr_q      <= addr_d;
            buf_full_q  <= buf_full_d;
            cfg_last_q  <= cfg_last_d;
            cfg_u2_q    <= cfg_u2_d;
            cfg_fract_q <= cfg_fract_d;
            cfg_bits_q  <= cfg_bits_d;
        end
    end

    // NOTE: the output registers are reset too, not only the control state,
    // so every output reads 0 as soon as rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en    <= 1'b0;
            wr_sel   <= 1'b0;
            wr_addr  <= '0;
            wr_x     <= '0;
            wr_d     <= '0;
            blk_done <= 1'b0;
            blk_sel  <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            wr_en    <= wr_en_d;
            wr_sel   <= wr_sel_d;
            wr_addr  <= wr_addr_d;
            wr_x     <= wr_x_d;
            wr_d     <= wr_d_d;
            blk_done <= blk_done_d;
            blk_sel  <= blk_sel_d;
            sat_flag <= sat_flag_d;
        end
    end

endmodule

// File: tb/tb_nlms_sample_loader.sv
// -----------------------------------------------------------------------------
// tb_nlms_sample_loader
//
// Self-checking bench for nlms_sample_loader (SW=16, Q=8, depth 128).
// A table of conversion vectors is applied one sample per started block.
// Hand-written sequences cover block switching, stalls, release timing, abort
// and reset. Expected writes go into a scoreboard queue when a pair is
// accepted, and a monitor pops and compares them when wr_en appears.
// -----------------------------------------------------------------------------
module tb_nlms_sample_loader;

    localparam int AW  = 7;
    localparam int SW  = 16;
    localparam int NBW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            start, abort;
    logic [AW:0]     cfg_count;
    logic            cfg_u2, cfg_fract;
    logic [NBW-1:0]  cfg_input_bits;
    logic            s_valid, s_ready;
    logic [SW-1:0]   s_x, s_d;
    logic            wr_en, wr_sel;
    logic [AW-1:0]   wr_addr;
    logic [SW-1:0]   wr_x, wr_d;
    logic            blk_done, blk_sel;
    logic            rel, rel_sel;
    logic            busy, sat_flag;

    nlms_sample_loader #(
        .LOG2_X_D_BUFF_HEIGHT(AW),
        .SAMPLE_WIDTH(SW),
        .SAMPLE_Q_FORMAT(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_count(cfg_count), .cfg_u2(cfg_u2), .cfg_fract(cfg_fract),
        .cfg_input_bits(cfg_input_bits),
        .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_d(s_d),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_x(wr_x), .wr_d(wr_d),
        .blk_done(blk_done), .blk_sel(blk_sel),
        .rel(rel), .rel_sel(rel_sel),
        .busy(busy), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sel;
        logic [AW-1:0] addr;
        logic [SW-1:0] x;
        logic [SW-1:0] d;
        logic          blk;
    } wr_t;

    typedef struct {
        logic           u2;
        logic           fract;
        logic [NBW-1:0] nbits;
        logic [SW-1:0]  x;
        logic [SW-1:0]  d;
        logic [SW-1:0]  ex;
        logic [SW-1:0]  ed;
        logic           esat;
    } vec_t;

    wr_t  sb[$];
    vec_t vt[11];
    int   vectors = 0;
    int   miscompares = 0;

    // Expected write position while streaming.
    int   m_addr;
    int   m_last;
    logic m_sel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write monitor: every wr_en must match the oldest expected write.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (!rst) begin
            if (wr_en) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_wr: got write sel %0d addr %0d, expected none (t=%0t)",
                             wr_sel, wr_addr, $time);
                end else begin
                    e = sb.pop_front();
                    check("wr_sel",   {31'b0, wr_sel},   {31'b0, e.sel});
                    check("wr_addr",  {25'b0, wr_addr},  {25'b0, e.addr});
                    check("wr_x",     {16'b0, wr_x},     {16'b0, e.x});
                    check("wr_d",     {16'b0, wr_d},     {16'b0, e.d});
                    check("blk_done", {31'b0, blk_done}, {31'b0, e.blk});
                    if (e.blk)
                        check("blk_sel", {31'b0, blk_sel}, {31'b0, e.sel});
                end
            end else if (blk_done) begin
                vectors++;
                miscompares++;
                $display("FAIL blk_without_wr: got blk_done=1 with wr_en=0, expected 0 (t=%0t)", $time);
            end
        end
    end

    task automatic do_start(input logic [AW:0] cnt, input logic u2, input logic fr,
                            input logic [NBW-1:0] nb);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort          = 1'b0;
        start          = 1'b1;
        cfg_count      = cnt;
        cfg_u2         = u2;
        cfg_fract      = fr;
        cfg_input_bits = nb;
        @(negedge clk);
        start  = 1'b0;
        m_addr = 0;
        m_sel  = 1'b0;
        m_last = (cnt == 0) ? (1 << AW) - 1 : int'(cnt) - 1;
    endtask

    // Streams n pairs with s_valid held high. Config must be u2=1, integer,
    // N=8, so the expected value is simply the low byte moved up by 8 bits.
    // rel_at > 0 pulses rel (buffer rs) on the edge that accepts pair rel_at.
    task automatic stream(input int n, input int rel_at, input logic rs);
        int            acc = 0;
        int            cyc = 0;
        logic          rdy;
        logic [SW-1:0] x, d;
        wr_t           w;
        while (acc < n && cyc < 400) begin
            @(negedge clk);
            x       = 16'($urandom);
            d       = 16'($urandom);
            s_valid = 1'b1;
            s_x     = x;
            s_d     = d;
            rdy     = s_ready;
            rel     = rdy && (acc + 1 == rel_at);
            rel_sel = rs;
            @(posedge clk);
            cyc++;
            if (rdy) begin
                w.sel  = m_sel;
                w.addr = AW'(m_addr);
                w.x    = {x[7:0], 8'h00};
                w.d    = {d[7:0], 8'h00};
                w.blk  = (m_addr == m_last);
                sb.push_back(w);
                if (m_addr == m_last) begin
                    m_addr = 0;
                    m_sel  = ~m_sel;
                end else begin
                    m_addr++;
                end
                acc++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        rel     = 1'b0;
        if (acc < n) begin
            vectors++;
            miscompares++;
            $display("FAIL stream_timeout: got %0d accepts, expected %0d", acc, n);
        end
    endtask

    task automatic drain();
        int c = 0;
        while (sb.size() != 0 && c < 20) begin
            @(negedge clk);
            #1;
            c++;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          u2    fr    N      x        d        exp x    exp d    sat
        vt[0]  = '{1'b1, 1'b0, 5'd16, 16'h0003, 16'hFFFF, 16'h0300, 16'hFF00, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 5'd16, 16'h00C8, 16'h0000, 16'h7FFF, 16'h0000, 1'b1};
        vt[2]  = '{1'b1, 1'b0, 5'd16, 16'hFF38, 16'h007F, 16'h8000, 16'h7F00, 1'b1};
        vt[3]  = '{1'b1, 1'b1, 5'd16, 16'h4000, 16'h8000, 16'h0080, 16'hFF00, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 5'd12, 16'h0000, 16'h0FFF, 16'hFF00, 16'h00FF, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 5'd12, 16'h0800, 16'hF800, 16'h0000, 16'h0000, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 5'd4,  16'h0007, 16'h0008, 16'h00E0, 16'hFF00, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 5'd8,  16'h007F, 16'h0080, 16'h7F00, 16'h8000, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 5'd16, 16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 5'd1,  16'h0000, 16'h0001, 16'hFF00, 16'h0000, 1'b0};
        vt[10] = '{1'b1, 1'b1, 5'd1,  16'h0001, 16'h0000, 16'hFF00, 16'h0000, 1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_count = '0; cfg_u2 = 1'b0;
        cfg_fract = 1'b0; cfg_input_bits = '0; s_valid = 1'b0; s_x = '0; s_d = '0;
        rel = 1'b0; rel_sel = 1'b0;
        m_addr = 0; m_sel = 1'b0; m_last = 7;

        // Reset state.
        #12;
        check("rst_s_ready",  {31'b0, s_ready},  0);
        check("rst_wr_en",    {31'b0, wr_en},    0);
        check("rst_busy",     {31'b0, busy},     0);
        check("rst_blk_done", {31'b0, blk_done}, 0);
        check("rst_sat_flag", {31'b0, sat_flag}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Conversion table: one sample per started block (cnt=8).
        foreach (vt[i]) begin
            wr_t w;
            do_start(8'd8, vt[i].u2, vt[i].fract, vt[i].nbits);
            s_valid = 1'b1;
            s_x     = vt[i].x;
            s_d     = vt[i].d;
            w.sel = 1'b0; w.addr = '0; w.x = vt[i].ex; w.d = vt[i].ed; w.blk = 1'b0;
            sb.push_back(w);
            @(negedge clk);
            s_valid = 1'b0;
            drain();
            check($sformatf("sat_flag_v%0d", i), {31'b0, sat_flag}, {31'b0, vt[i].esat});
        end

        // cnt=8, continuous: 8 to ping, 8 to pong, then stall.
        do_start(8'd8, 1'b1, 1'b0, 5'd8);
        check("busy_fill",  {31'b0, busy},    1);
        check("ready_fill", {31'b0, s_ready}, 1);
        stream(16, 0, 1'b0);
        check("ready_wait", {31'b0, s_ready}, 0);
        drain();
        s_valid = 1'b1;
        repeat (2) @(negedge clk);
        s_valid = 1'b0;
        check("ready_still_wait", {31'b0, s_ready}, 0);
        rel = 1'b1; rel_sel = 1'b0;
        @(negedge clk);
        rel = 1'b0;
        check("ready_after_rel", {31'b0, s_ready}, 1);
        stream(1, 0, 1'b0);
        // Releasing ping while it is being filled (not full) must not matter.
        @(negedge clk);
        rel = 1'b1; rel_sel = 1'b0;
        @(negedge clk);
        rel = 1'b0;
        stream(7, 0, 1'b0);
        check("ready_rel_ignored", {31'b0, s_ready}, 0);
        drain();

        // Release on the same edge as the 16th acceptance: no stall.
        do_start(8'd8, 1'b1, 1'b0, 5'd8);
        stream(16, 16, 1'b0);
        check("ready_same_edge_rel", {31'b0, s_ready}, 1);
        stream(1, 0, 1'b0);
        drain();

        // Abort after 3 accepts, with a pair presented on the abort edge.
        do_start(8'd8, 1'b1, 1'b0, 5'd8);
        stream(3, 0, 1'b0);
        @(negedge clk);
        abort = 1'b1; s_valid = 1'b1; s_x = 16'h1234; s_d = 16'h5678;
        @(negedge clk);
        abort = 1'b0; s_valid = 1'b0;
        check("abort_ready", {31'b0, s_ready}, 0);
        check("abort_busy",  {31'b0, busy},    0);
        drain();
        do_start(8'd8, 1'b1, 1'b0, 5'd8);
        stream(1, 0, 1'b0);
        drain();

        // Reset mid-block while the 3rd write is on the port.
        do_start(8'd8, 1'b1, 1'b0, 5'd8);
        stream(3, 0, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_wr_en",   {31'b0, wr_en},   0);
        check("rst_mid_wr_addr", {25'b0, wr_addr}, 0);
        check("rst_mid_wr_x",    {16'b0, wr_x},    0);
        check("rst_mid_s_ready", {31'b0, s_ready}, 0);
        check("rst_mid_busy",    {31'b0, busy},    0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        do_start(8'd8, 1'b1, 1'b0, 5'd8);
        stream(1, 0, 1'b0);
        drain();

        // cnt=0 means full depth: block of 128, then start of the pong block.
        do_start(8'd0, 1'b1, 1'b0, 5'd8);
        stream(131, 0, 1'b0);
        check("ready_depth", {31'b0, s_ready}, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
